// File: rtl/ac3_quant_bank_if.sv
// Load/stream bundle for ac3_quant_bank: parallel channel load in, one channel per beat out.
// Pure wiring, no latency.
// out_valid/out_ready follow valid/ready rules; the consumer stalls via out_ready.
interface ac3_quant_bank_if #(
   parameter int M   = 16,
   parameter int Pa  = 8,
   parameter int Pw  = 8,
   parameter int MNO = 288,
   parameter int NCH = 4,
   parameter int Po  = 8
);
   localparam int W  = $clog2(M) + Pa + Pw + $clog2(MNO);
   localparam int SW = $clog2(W);
   localparam int CW = $clog2(NCH);

   logic                cl_en;
   logic                w_en;
   logic [NCH*W-1:0]    in_vec;
   logic [SW-1:0]       sh_amt;
   logic                busy;
   logic                out_valid;
   logic                out_ready;
   logic [Po-1:0]       out_data;
   logic [CW-1:0]       out_ch;
   logic                out_sat;
   logic                done;

   modport master (
      output cl_en, w_en, in_vec, sh_amt, out_ready,
      input  busy, out_valid, out_data, out_ch, out_sat, done
   );

   modport slave (
      input  cl_en, w_en, in_vec, sh_amt, out_ready,
      output busy, out_valid, out_data, out_ch, out_sat, done
   );
endinterface

// File: rtl/ac3_quant_bank.sv
// NCH-channel quantizer: parallel load, shared arithmetic right shift, saturate to Po, stream out.
// Latency: load to first beat is min(sh_amt, W-1)+1 cycles; AC3_QUANT_ROUND_EN adds round-half-up.
// Backpressure: out_ready low holds the current beat (data, channel, sat flag) stable.
module ac3_quant_bank #(
   parameter int M   = 16,
   parameter int Pa  = 8,
   parameter int Pw  = 8,
   parameter int MNO = 288,
   parameter int NCH = 4,
   parameter int Po  = 8
) (
   input logic               clk,
   input logic               rst_n,
   ac3_quant_bank_if.slave   bus
);
   localparam int W  = $clog2(M) + Pa + Pw + $clog2(MNO);
   localparam int SW = $clog2(W);
   localparam int CW = $clog2(NCH);

   localparam logic signed [W:0] SAT_HI = (W+1)'((1 << (Po - 1)) - 1);
   localparam logic signed [W:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

   state_t                state;
   logic signed [W-1:0]   acc [NCH];
   logic [SW-1:0]         cnt;
   logic [SW-1:0]         sh_clamp;
   logic [CW-1:0]         ch;
   logic                  busy;
   logic                  valid;
   logic                  done;
   logic signed [W:0]     val;
   logic [Po-1:0]         sat_data;
   logic                  sat_flag;
`ifdef AC3_QUANT_ROUND_EN
   logic [NCH-1:0]        guard;
`endif

   // Shifts of W or more would only sign-fill, so W-1 gives the same result.
   assign sh_clamp = (int'(bus.sh_amt) >= W) ? SW'(W - 1) : bus.sh_amt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         for (int i = 0; i < NCH; i++) acc[i] <= '0;
         cnt   <= '0;
         ch    <= '0;
         busy  <= 1'b0;
         valid <= 1'b0;
         done  <= 1'b0;
`ifdef AC3_QUANT_ROUND_EN
         guard <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (bus.cl_en) begin
            state <= IDLE;
            for (int i = 0; i < NCH; i++) acc[i] <= '0;
            cnt   <= '0;
            ch    <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
`ifdef AC3_QUANT_ROUND_EN
            guard <= '0;
`endif
         end else begin
            unique case (state)
               IDLE: begin
                  if (bus.w_en) begin
                     for (int i = 0; i < NCH; i++) acc[i] <= bus.in_vec[i*W +: W];
`ifdef AC3_QUANT_ROUND_EN
                     guard <= '0;
`endif
                     cnt  <= sh_clamp;
                     busy <= 1'b1;
                     if (sh_clamp != '0) begin
                        state <= SHIFT;
                     end else begin
                        state <= OUT;
                        valid <= 1'b1;
                     end
                  end
               end
               SHIFT: begin
                  for (int i = 0; i < NCH; i++) begin
                     acc[i] <= acc[i] >>> 1;
`ifdef AC3_QUANT_ROUND_EN
                     guard[i] <= acc[i][0];
`endif
                  end
                  cnt <= cnt - SW'(1);
                  if (cnt == SW'(1)) begin
                     state <= OUT;
                     valid <= 1'b1;
                  end
               end
               OUT: begin
                  if (bus.out_ready) begin
                     if (ch == CW'(NCH - 1)) begin
                        ch    <= '0;
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                     end else begin
                        ch <= ch + CW'(1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // One extra bit so the rounding increment cannot wrap the largest positive value.
   always_comb begin
      val = {acc[ch][W-1], acc[ch]};
`ifdef AC3_QUANT_ROUND_EN
      val = val + $signed({{W{1'b0}}, guard[ch]});
`endif
      sat_data = val[Po-1:0];
      sat_flag = 1'b0;
      if (val > SAT_HI) begin
         sat_data = SAT_HI[Po-1:0];
         sat_flag = 1'b1;
      end else if (val < SAT_LO) begin
         sat_data = SAT_LO[Po-1:0];
         sat_flag = 1'b1;
      end
   end

   assign bus.busy      = busy;
   assign bus.out_valid = valid;
   assign bus.out_data  = sat_data;
   assign bus.out_ch    = ch;
   assign bus.out_sat   = sat_flag;
   assign bus.done      = done;
endmodule

// File: tb/tb_ac3_quant_bank.sv
// Directed bench for ac3_quant_bank at default parameters (W=29, NCH=4, Po=8).
// Expected beats are hand-computed; the rounding build selects its own expectation set.
module tb_ac3_quant_bank;
   localparam int W = 29;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int   bd [8];
   int   bc [8];
   bit   bs [8];
   int   nb, nshift, nfirst, ndone, nunstable, ntimeout;

   ac3_quant_bank_if bus ();

   ac3_quant_bank dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [4*W-1:0] pack(int a, int b, int c, int d);
      logic [4*W-1:0] v;
      v[0*W +: W] = W'(a);
      v[1*W +: W] = W'(b);
      v[2*W +: W] = W'(c);
      v[3*W +: W] = W'(d);
      return v;
   endfunction

   task automatic load(input logic [4*W-1:0] vec, input int sh);
      bus.in_vec = vec;
      bus.sh_amt = 5'(sh);
      bus.w_en   = 1'b1;
      @(negedge clk);
      bus.w_en   = 1'b0;
   endtask

   // Observes one output stream; cycle 0 is the negedge just after the load edge.
   task automatic collect(input int stall_ch, input int stall_n, input bit poke, input int budget);
      int  stall_left;
      bit  have_ref;
      int  ref_d, ref_c;
      bit  ref_s;
      nb = 0; nshift = 0; nfirst = -1; ndone = 0; nunstable = 0; ntimeout = 1;
      stall_left = stall_n;
      have_ref = 0; ref_d = 0; ref_c = 0; ref_s = 0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         bus.w_en = 1'b0;
         if (bus.done) begin
            ndone++;
            ntimeout = 0;
            break;
         end
         if (bus.busy && !bus.out_valid) nshift++;
         if (bus.out_valid) begin
            if (nfirst < 0) nfirst = cyc;
            if (int'(bus.out_ch) == stall_ch && stall_left > 0) begin
               bus.out_ready = 1'b0;
               if (!have_ref) begin
                  ref_d = int'($signed(bus.out_data));
                  ref_c = int'(bus.out_ch);
                  ref_s = bus.out_sat;
                  have_ref = 1;
               end else if (ref_d != int'($signed(bus.out_data)) ||
                            ref_c != int'(bus.out_ch) || ref_s != bus.out_sat) begin
                  nunstable++;
               end
               stall_left--;
            end else begin
               bus.out_ready = 1'b1;
               if (nb < 8) begin
                  bd[nb] = int'($signed(bus.out_data));
                  bc[nb] = int'(bus.out_ch);
                  bs[nb] = bus.out_sat;
               end
               nb++;
               if (poke && nb == 2) begin
                  bus.in_vec = pack(99, 99, 99, 99);
                  bus.sh_amt = 5'd0;
                  bus.w_en   = 1'b1;
               end
            end
         end else begin
            bus.out_ready = 1'b1;
         end
         @(negedge clk);
      end
      bus.w_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
   endtask

   task automatic test_reset();
      bus.cl_en = 0; bus.w_en = 0; bus.in_vec = '0; bus.sh_amt = '0; bus.out_ready = 1;
      rst_n = 1'b0;
      #12;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.out_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", bus.out_data); end
      checks++; if (bus.out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", bus.out_ch); end
      checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", bus.out_sat); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_stream(input string name, input int ed [4], input bit es [4],
                               input int exp_first, input int exp_shift);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= nb || bd[i] !== ed[i] || bc[i] !== i || bs[i] !== es[i]) begin
            errors++;
            $display("FAIL %s beat%0d: got data=%0d ch=%0d sat=%0d, expected data=%0d ch=%0d sat=%0d",
                     name, i, bd[i], bc[i], bs[i], ed[i], i, es[i]);
         end
      end
      checks++; if (nb !== 4) begin errors++; $display("FAIL %s beats: got %0d expected 4", name, nb); end
      checks++; if (ndone !== 1 || ntimeout !== 0) begin errors++; $display("FAIL %s done: got %0d pulses (timeout=%0d) expected 1", name, ndone, ntimeout); end
      checks++; if (nfirst !== exp_first) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, nfirst, exp_first); end
      checks++; if (nshift !== exp_shift) begin errors++; $display("FAIL %s shift_cycles: got %0d expected %0d", name, nshift, exp_shift); end
   endtask

   task automatic test_quant_basic();
`ifdef AC3_QUANT_ROUND_EN
      int ed [4] = '{125, -125, 5, -5};
`else
      int ed [4] = '{125, -125, 4, -5};
`endif
      bit es [4] = '{0, 0, 0, 0};
      load(pack(1000, -1000, 37, -37), 3);
      collect(-1, 0, 0, 60);
      check_stream("basic", ed, es, 3, 3);
   endtask

   task automatic test_saturation();
`ifdef AC3_QUANT_ROUND_EN
      int ed [4] = '{127, -128, 8, -8};
`else
      int ed [4] = '{127, -128, 7, -8};
`endif
      bit es [4] = '{1, 1, 0, 0};
      load(pack(70000, -70000, 127, -128), 4);
      collect(-1, 0, 0, 60);
      check_stream("sat", ed, es, 4, 4);
   endtask

   task automatic test_back_to_back_stall();
`ifdef AC3_QUANT_ROUND_EN
      int ed [4] = '{125, -125, 5, -5};
`else
      int ed [4] = '{125, -125, 4, -5};
`endif
      bit es [4] = '{0, 0, 0, 0};
      load(pack(1000, -1000, 37, -37), 3);
      collect(1, 5, 0, 60);
      check_stream("stall", ed, es, 3, 3);
      checks++; if (nunstable !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", nunstable); end
   endtask

   task automatic test_clear();
      int nv, nd;
      int ed [4] = '{10, -20, 127, -128};
      bit es [4] = '{0, 0, 1, 1};
      load(pack(1000, -1000, 37, -37), 5);
      @(negedge clk);
      bus.cl_en = 1'b1;
      @(negedge clk);
      bus.cl_en = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b expected 0", bus.out_valid); end
      nv = 0; nd = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid) nv++;
         if (bus.done) nd++;
         @(negedge clk);
      end
      checks++; if (nv !== 0 || nd !== 0) begin errors++; $display("FAIL clear_quiet: got valid=%0d done=%0d expected 0 0", nv, nd); end
      load(pack(10, -20, 200, -200), 0);
      collect(-1, 0, 0, 60);
      check_stream("raw", ed, es, 0, 0);
   endtask

   task automatic test_clamp_ignore_wen();
`ifdef AC3_QUANT_ROUND_EN
      int ed [4] = '{0, 0, -1, 1};
`else
      int ed [4] = '{-1, 0, -1, 0};
`endif
      bit es [4] = '{0, 0, 0, 0};
      load(pack(-1, 5, -(1 << 28), (1 << 28) - 1), 31);
      collect(-1, 0, 1, 120);
      check_stream("clamp", ed, es, 28, 28);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clamp_idle: got busy=%b expected 0", bus.busy); end
   endtask

   initial begin
      test_reset();
      test_quant_basic();
      test_saturation();
      test_back_to_back_stall();
      test_clear();
      test_clamp_ignore_wen();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
